// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake and data bundle for the digit-serial BCD adder controller.
//   start  : request an addition (master -> slave)
//   a, b   : packed BCD operands, digit 0 in bits [3:0] (master -> slave)
//   cin    : carry into digit 0 (master -> slave)
//   busy   : addition in progress (slave -> master)
//   done   : one-cycle completion pulse (slave -> master)
//   s      : packed BCD sum (slave -> master)
//   cout   : carry out of the most significant digit (slave -> master)
//   err    : a latched operand digit was >9 (slave -> master)
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 3
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   s;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller. A single one-digit BCD add/correct
// stage is sequenced across DIGITS packed-BCD digits, least significant
// digit first, one digit per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_serial_add_ctrl_if (start/a/b/cin in,
//           busy/done/s/cout/err out)
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 3,
    parameter int IDXW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_serial_add_ctrl_if.slave    bus
);
    localparam int          W    = 4 * DIGITS;
    localparam int unsigned LAST = DIGITS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      s_q, s_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;

    logic [3:0]        a_dig;
    logic [3:0]        b_dig;
    logic [4:0]        p;
    logic [4:0]        q;
    logic              bad_digit;
    logic              last_digit;

    // Operand digit selected by the current index.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (32'(idx_q) == i) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
    end

    // One-digit BCD add with decimal correction; 5-bit truncating
    // arithmetic also applies to invalid (>9) digits.
    always_comb begin
        p = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        q = (p > 5'd9) ? (p + 5'd6) : p;
    end

    assign last_digit = (32'(idx_q) == LAST);

    // Any non-decimal digit on the incoming operands.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9) bad_digit = 1'b1;
            if (bus.b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    err_d   = bad_digit;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (32'(idx_q) == i) s_d[4*i +: 4] = q[3:0];
                end
                carry_d = q[4];
                if (last_digit) begin
                    // Index wraps to zero so it never leaves 0..DIGITS-1.
                    cout_d  = q[4];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == ADD);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule
